// File: rtl/lsu_ctrl_pkg.sv
// Shared definitions for the load/store controller: state encodings and word geometry.
// The encodings match the ones the pipelined LSU will reuse.
package lsu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } lsu_state_e;

  localparam int WORD_BYTES = 4;
  localparam int WORD_BITS  = 32;

  function automatic logic is_misaligned(input logic [1:0] addr_lsbs);
    return addr_lsbs != 2'b00;
  endfunction

endpackage

// File: rtl/lsu_ctrl_sat_counter.sv
// Saturating event counter: sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: one request at a time, alignment/bounds check,
// a single-cycle data_mem access, then a held response until handshake.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 64,
  parameter int MEM_BYTES = 1024,
  parameter int CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  // Both channels: a beat transfers on a posedge where valid && ready; valid,
  // once raised, holds its payload stable until that edge.
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              memwrite,
  output logic              memread,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic [CNT_W-1:0]  load_count,
  output logic [CNT_W-1:0]  store_count,
  output logic [1:0]        dbg_state
);

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MEM_BYTES - WORD_BYTES);
  localparam int                EXT_W     = DATA_W - WORD_BITS;

  lsu_state_e          r_state;
  lsu_state_e          w_next_state;
  logic                r_write;
  logic                r_unsigned;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_memread;
  logic                r_memwrite;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_err;

  logic                w_bad;
  logic [WORD_BITS-1:0] w_word;
  logic [DATA_W-1:0]   w_ext;
  logic                w_in_access;
  logic                w_resp_hs;
  logic                w_load_done;
  logic                w_store_done;
  logic                w_unused;

  assign w_bad       = is_misaligned(req_addr[1:0]) || (req_addr > LAST_WORD);
  assign w_word      = mem_data_out[WORD_BITS-1:0];
  assign w_ext       = r_unsigned ? {{EXT_W{1'b0}}, w_word}
                                  : {{EXT_W{w_word[WORD_BITS-1]}}, w_word};
  assign w_unused    = ^mem_data_out[DATA_W-1:WORD_BITS];
  assign w_in_access = (r_state == ST_ACCESS);
  assign w_resp_hs   = (r_state == ST_RESP) && resp_ready;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (req_valid) w_next_state = w_bad ? ST_RESP : ST_ACCESS;
      ST_ACCESS: w_next_state = ST_RESP;
      ST_RESP:   if (resp_ready) w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // memread/memwrite are registers so an async reset drops them before any negedge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_write    <= 1'b0;
      r_unsigned <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_write    <= req_write;
            r_unsigned <= req_unsigned;
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            r_rdata    <= '0;
            r_err      <= w_bad;
            r_memread  <= !w_bad && !req_write;
            r_memwrite <= !w_bad && req_write;
          end
        end
        ST_ACCESS: begin
          r_memread  <= 1'b0;
          r_memwrite <= 1'b0;
          r_rdata    <= r_write ? '0 : w_ext;
        end
        ST_RESP: begin
          if (resp_ready) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign w_load_done  = w_resp_hs && !r_err && !r_write;
  assign w_store_done = w_resp_hs && !r_err && r_write;

  sat_counter #(.W(CNT_W)) u_load_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_load_done),
    .count (load_count)
  );

  sat_counter #(.W(CNT_W)) u_store_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_store_done),
    .count (store_count)
  );

  assign req_ready   = (r_state == ST_IDLE);
  assign resp_valid  = (r_state == ST_RESP);
  assign resp_rdata  = r_rdata;
  assign resp_err    = r_err;
  assign memread     = r_memread;
  assign memwrite    = r_memwrite;
  assign mem_address = w_in_access ? r_addr : '0;
  assign mem_data_in = (w_in_access && r_write) ? r_wdata : '0;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: byte-array data_mem, transaction-level reference model
// checked every negedge, directed literal cases, then random traffic.
module tb_lsu_ctrl;

  localparam int AW  = 64;
  localparam int DW  = 64;
  localparam int MB  = 1024;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic          req_unsigned = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [DW-1:0] resp_rdata;
  logic          resp_err;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data_in;
  logic          memwrite;
  logic          memread;
  logic [DW-1:0] mem_data_out = '0;
  logic [CW-1:0] load_count;
  logic [CW-1:0] store_count;
  logic [1:0]    dbg_state;

  lsu_ctrl #(.ADDR_W(AW), .DATA_W(DW), .MEM_BYTES(MB), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .memwrite     (memwrite),
    .memread      (memread),
    .mem_data_out (mem_data_out),
    .load_count   (load_count),
    .store_count  (store_count),
    .dbg_state    (dbg_state)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] init_byte(input int i);
    logic [31:0] w0, w8;
    w0 = 32'd1000;
    w8 = 32'hFFFF_FF38;
    if (i < 4)                return w0[8*(3-i) +: 8];
    else if (i >= 8 && i < 12) return w8[8*(11-i) +: 8];
    else                       return 8'(i * 37 + 11);
  endfunction

  // data_mem: acts on negedge, big-endian words
  logic [7:0] dmem [0:MB-1];
  bit dm_init = 1'b0;
  int dm_a;
  always @(negedge clk) begin
    if (!dm_init) begin
      for (int i = 0; i < MB; i++) dmem[i] = init_byte(i);
      dm_init = 1'b1;
    end
    dm_a = int'(mem_address[9:0]);
    if (memwrite && dm_a <= MB - 4) begin
      dmem[dm_a]     = mem_data_in[31:24];
      dmem[dm_a + 1] = mem_data_in[23:16];
      dmem[dm_a + 2] = mem_data_in[15:8];
      dmem[dm_a + 3] = mem_data_in[7:0];
    end
    if (memread && dm_a <= MB - 4)
      mem_data_out <= {32'h0, dmem[dm_a], dmem[dm_a + 1], dmem[dm_a + 2], dmem[dm_a + 3]};
  end

  // reference model: one outstanding transaction tracked by its cycle stamps
  logic [7:0]  ref_mem [0:MB-1];
  bit          ref_init = 1'b0;
  bit          m_busy = 1'b0;
  logic        m_w, m_u, m_err;
  logic [63:0] m_addr, m_wdata, m_rdata;
  int          m_mem_cyc, m_resp_cyc;
  int          m_lc = 0, m_sc = 0;
  int          n_rd_cyc = 0, n_wr_cyc = 0;
  logic        exp_op, exp_rv;
  logic [31:0] m_word;
  int          ra;

  always @(negedge clk) begin
    if (!ref_init) begin
      for (int i = 0; i < MB; i++) ref_mem[i] = init_byte(i);
      ref_init = 1'b1;
    end
    if (memread)  n_rd_cyc++;
    if (memwrite) n_wr_cyc++;
    if (!rst_n) begin
      m_busy = 1'b0;
      m_lc = 0;
      m_sc = 0;
      check("rst_req_ready", 64'(req_ready), 64'd1);
      check("rst_resp_valid", 64'(resp_valid), 64'd0);
      check("rst_memrw", 64'({memread, memwrite}), 64'd0);
      check("rst_mem_address", mem_address, 64'd0);
      check("rst_resp", {resp_rdata[62:0], resp_err}, 64'd0);
      check("rst_counts", 64'({load_count, store_count}), 64'd0);
    end else begin
      exp_op = m_busy && !m_err && (cyc == m_mem_cyc);
      if (exp_op) begin
        ra = int'(m_addr[9:0]);
        if (m_w) begin
          ref_mem[ra]     = m_wdata[31:24];
          ref_mem[ra + 1] = m_wdata[23:16];
          ref_mem[ra + 2] = m_wdata[15:8];
          ref_mem[ra + 3] = m_wdata[7:0];
          m_rdata = 64'd0;
        end else begin
          m_word  = {ref_mem[ra], ref_mem[ra + 1], ref_mem[ra + 2], ref_mem[ra + 3]};
          m_rdata = m_u ? {32'h0, m_word} : {{32{m_word[31]}}, m_word};
        end
      end
      exp_rv = m_busy && (cyc >= m_resp_cyc);
      check("req_ready", 64'(req_ready), 64'(!m_busy));
      check("resp_valid", 64'(resp_valid), 64'(exp_rv));
      check("memread", 64'(memread), 64'(exp_op && !m_w));
      check("memwrite", 64'(memwrite), 64'(exp_op && m_w));
      check("mem_address", mem_address, exp_op ? m_addr : 64'd0);
      if (!exp_op || m_w)
        check("mem_data_in", mem_data_in, exp_op ? m_wdata : 64'd0);
      check("resp_rdata", resp_rdata, exp_rv ? m_rdata : 64'd0);
      check("resp_err", 64'(resp_err), 64'(exp_rv && m_err));
      check("load_count", 64'(load_count), 64'(m_lc));
      check("store_count", 64'(store_count), 64'(m_sc));
      if (resp_valid && resp_ready) begin
        if (!m_err) begin
          if (m_w) m_sc = (m_sc == SAT) ? SAT : m_sc + 1;
          else     m_lc = (m_lc == SAT) ? SAT : m_lc + 1;
        end
        m_busy = 1'b0;
      end
      if (req_valid && req_ready) begin
        m_busy     = 1'b1;
        m_w        = req_write;
        m_u        = req_unsigned;
        m_addr     = req_addr;
        m_wdata    = req_wdata;
        m_rdata    = 64'd0;
        m_err      = (req_addr[1:0] != 2'b00) || (req_addr > 64'(MB - 4));
        m_mem_cyc  = cyc + 1;
        m_resp_cyc = m_err ? cyc + 1 : cyc + 2;
      end
    end
  end

  // driver tasks: each starts and ends just after a posedge
  task automatic run_txn(input logic w, input logic u, input logic [63:0] addr,
                         input logic [63:0] wd, input int stall, input bit hold_next,
                         output logic [63:0] rd, output logic er, output int lat,
                         output int acc_c, output int hs_c);
    int n;
    rd = '0; er = 1'b0; lat = -1; acc_c = -1; hs_c = -1;
    req_valid = 1'b1; req_write = w; req_unsigned = u; req_addr = addr; req_wdata = wd;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 40);
    if (!req_ready) begin
      check("accept_timeout", 64'd0, 64'd1);
      return;
    end
    acc_c = cyc;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_wdata = {$urandom, $urandom};
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!resp_valid && n < 40);
    if (!resp_valid) begin
      check("resp_timeout", 64'd0, 64'd1);
      return;
    end
    lat = cyc - acc_c;
    rd = resp_rdata;
    er = resp_err;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      if (hold_next && s == 0) begin
        req_valid = 1'b1; req_write = 1'b0; req_unsigned = 1'b0; req_addr = 64'd8;
      end
      @(negedge clk);
      check("stall_req_ready", 64'(req_ready), 64'd0);
      check("stall_resp_valid", 64'(resp_valid), 64'd1);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    @(negedge clk);
    hs_c = cyc;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  function automatic logic [63:0] rand_addr();
    case ($urandom_range(0, 11))
      7:       return {54'd0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
      8:       return 64'($urandom_range(256, 1023)) << 2;
      9:       return {$urandom, $urandom} & ~64'd3;
      10:      return 64'd1020;
      11:      return 64'd1024;
      default: return 64'($urandom_range(0, 255)) << 2;
    endcase
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [63:0] rd;
  logic        er;
  int          lat, acc_c, hs_c, acc2, hs2, wr0, rd0;
  logic [31:0] saved56;
  bit          acc;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    run_txn(1'b0, 1'b0, 64'd0, 64'd0, 0, 1'b0, rd, er, lat, acc_c, hs_c);
    check("ld0_data", rd, 64'd1000);
    check("ld0_err", 64'(er), 64'd0);
    check("ld0_latency", 64'(lat), 64'd2);
    check("ld0_count", 64'(load_count), 64'd1);

    run_txn(1'b0, 1'b0, 64'd8, 64'd0, 0, 1'b0, rd, er, lat, acc_c, hs_c);
    check("ld8_signed", rd, 64'hFFFF_FFFF_FFFF_FF38);
    run_txn(1'b0, 1'b1, 64'd8, 64'd0, 0, 1'b0, rd, er, lat, acc_c, hs_c);
    check("ld8_unsigned", rd, 64'h0000_0000_FFFF_FF38);

    wr0 = n_wr_cyc;
    run_txn(1'b1, 1'b0, 64'd48, 64'hDEAD_BEEF_1234_5678, 0, 1'b0, rd, er, lat, acc_c, hs_c);
    check("st48_ack_data", rd, 64'd0);
    check("st48_err", 64'(er), 64'd0);
    check("st48_memwrite_cycles", 64'(n_wr_cyc - wr0), 64'd1);
    check("st48_count", 64'(store_count), 64'd1);
    check("st48_byte0", 64'(dmem[48]), 64'h12);
    check("st48_byte3", 64'(dmem[51]), 64'h78);
    run_txn(1'b0, 1'b1, 64'd48, 64'd0, 0, 1'b0, rd, er, lat, acc_c, hs_c);
    check("ld48_unsigned", rd, 64'h0000_0000_1234_5678);

    rd0 = n_rd_cyc; wr0 = n_wr_cyc;
    run_txn(1'b0, 1'b0, 64'd2, 64'd0, 0, 1'b0, rd, er, lat, acc_c, hs_c);
    check("ld2_err", 64'(er), 64'd1);
    check("ld2_latency", 64'(lat), 64'd1);
    check("ld2_data", rd, 64'd0);
    run_txn(1'b1, 1'b0, 64'd1024, 64'h1111_2222_3333_4444, 0, 1'b0, rd, er, lat, acc_c, hs_c);
    check("st1024_err", 64'(er), 64'd1);
    check("st1024_latency", 64'(lat), 64'd1);
    check("err_no_mem_access", 64'({n_rd_cyc - rd0, n_wr_cyc - wr0}), 64'd0);
    check("err_counts", 64'({load_count, store_count}), 64'h41);

    run_txn(1'b0, 1'b0, 64'd0, 64'd0, 4, 1'b1, rd, er, lat, acc_c, hs_c);
    check("stall_ld0_data", rd, 64'd1000);
    run_txn(1'b0, 1'b0, 64'd8, 64'd0, 0, 1'b0, rd, er, lat, acc2, hs2);
    check("b2b_accept_after_hs", 64'(acc2 - hs_c), 64'd1);
    check("b2b_data", rd, 64'hFFFF_FFFF_FFFF_FF38);
    check("b2b_count", 64'(load_count), 64'd6);

    saved56 = {dmem[56], dmem[57], dmem[58], dmem[59]};
    req_valid = 1'b1; req_write = 1'b1; req_unsigned = 1'b0;
    req_addr = 64'd56; req_wdata = 64'hCAFE_F00D_A5A5_5A5A;
    @(negedge clk);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rst_pre_memwrite", 64'(memwrite), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_memwrite", 64'(memwrite), 64'd0);
    check("rst_mid_ready", 64'(req_ready), 64'd1);
    check("rst_mid_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_mid_counts", 64'({load_count, store_count}), 64'd0);
    repeat (2) @(negedge clk);
    check("rst_mem56_kept", 64'({dmem[56], dmem[57], dmem[58], dmem[59]}), 64'(saved56));
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      acc = req_valid && req_ready;
      @(posedge clk); #1;
      if (acc || !req_valid) begin
        if ($urandom_range(0, 2) != 0) begin
          req_valid    = 1'b1;
          req_write    = ($urandom_range(0, 2) == 0);
          req_unsigned = $urandom_range(0, 1) != 0;
          req_addr     = rand_addr();
          req_wdata    = {$urandom, $urandom};
        end else begin
          req_valid = 1'b0;
        end
      end
      resp_ready = ($urandom_range(0, 3) != 0);
    end

    req_valid = 1'b0;
    resp_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("final_idle", 64'(req_ready), 64'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
